// File: rtl/selftrigger_peak_discriminator.sv
// Self-trigger discriminator placed after the AFE-integrator IIR filter.
// Tracks the baseline with an exponential moving average, qualifies positive
// excursions by threshold, minimum width and hysteresis, reports the peak
// amplitude above baseline for each event and then enforces a dead time.
// Pipeline: capture (stage 1), difference/compare (stage 2), FSM (stage 3).

module selftrigger_peak_discriminator #(
    parameter int BASELINE_SHIFT = 6,
    parameter int MIN_WIDTH      = 4,
    parameter int DEADTIME       = 256,
    parameter int SETTLE_LOG2    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic signed [15:0] x_in,
    input  logic        [13:0] threshold,
    output logic               trigger,
    output logic               peak_valid,
    output logic signed [15:0] peak_amp,
    output logic signed [15:0] baseline_out,
    output logic               baseline_ready,
    output logic               busy,
    output logic        [31:0] trig_count
);

    localparam int ACC_W = 16 + BASELINE_SHIFT;
    localparam int SET_W = SETTLE_LOG2 + 1;
    localparam logic [SET_W-1:0] SETTLE_DONE = {1'b1, {SETTLE_LOG2{1'b0}}};
    localparam logic [SET_W-1:0] SETTLE_ONE  = {{SETTLE_LOG2{1'b0}}, 1'b1};
    localparam logic [3:0]       MIN_W       = 4'(MIN_WIDTH);
    localparam logic [15:0]      DEAD_LOAD   = 16'(DEADTIME);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DEAD      = 2'd3
    } state_t;

    // Peak is always positive in practice, but clamp both ends for safety.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        logic signed [15:0] r;
        if (v > 17'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -17'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Stage 1 registers
    logic signed [15:0] xr_q, xr_d;
    logic               v1_q, v1_d;
    // Stage 2 registers
    logic signed [15:0] xs_q, xs_d;
    logic signed [16:0] d_q, d_d;
    logic               above_q, above_d;
    logic               below_q, below_d;
    logic               v2_q, v2_d;
    // Baseline tracker
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    init_q, init_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic                    ready_q, ready_d;
    // Event FSM
    state_t             state_q, state_d;
    logic [3:0]         arm_q, arm_d;
    logic signed [16:0] peak_q, peak_d;
    logic [15:0]        dead_q, dead_d;
    logic               trig_q, trig_d;
    logic               pv_q, pv_d;
    logic signed [15:0] amp_q, amp_d;
    logic [31:0]        count_q, count_d;
    logic               busy_q, busy_d;

    logic signed [15:0]      baseline_s;
    logic signed [16:0]      diff_s;
    logic signed [16:0]      thr_s;
    logic signed [16:0]      thr_half_s;
    logic signed [16:0]      peak_max_s;
    logic signed [ACC_W-1:0] xs_ext_s;
    logic signed [ACC_W-1:0] base_ext_s;
    logic                    base_upd_s;

    // The top 16 bits of the accumulator are acc >>> BASELINE_SHIFT.
    assign baseline_s = acc_q[ACC_W-1:BASELINE_SHIFT];
    assign diff_s     = {xr_q[15], xr_q} - {baseline_s[15], baseline_s};
    assign thr_s      = {3'b000, threshold};
    assign thr_half_s = {4'b0000, threshold[13:1]};
    assign peak_max_s = (d_q > peak_q) ? d_q : peak_q;
    assign xs_ext_s   = {{BASELINE_SHIFT{xs_q[15]}}, xs_q};
    assign base_ext_s = {{BASELINE_SHIFT{baseline_s[15]}}, baseline_s};

    // Stage 1: capture the sample only on enabled edges; valid travels with it.
    always_comb begin
        xr_d = xr_q;
        v1_d = 1'b0;
        if (enable) begin
            xr_d = x_in;
            v1_d = 1'b1;
        end else begin
            xr_d = xr_q;
            v1_d = 1'b0;
        end
    end

    // Stage 2: difference against the current baseline plus both compares.
    always_comb begin
        xs_d    = xs_q;
        d_d     = d_q;
        above_d = above_q;
        below_d = below_q;
        v2_d    = v1_q;
        if (v1_q) begin
            xs_d    = xr_q;
            d_d     = diff_s;
            above_d = (diff_s > thr_s);
            below_d = (diff_s < thr_half_s);
        end else begin
            xs_d    = xs_q;
        end
    end

    // Baseline EMA and settling counter; only advanced by samples that stay in IDLE.
    always_comb begin
        acc_d    = acc_q;
        init_d   = init_q;
        settle_d = settle_q;
        ready_d  = ready_q;
        if (base_upd_s) begin
            if (init_q) begin
                acc_d = acc_q + xs_ext_s - base_ext_s;
            end else begin
                acc_d  = {xs_q, {BASELINE_SHIFT{1'b0}}};
                init_d = 1'b1;
            end
            if (!ready_q) begin
                settle_d = settle_q + SETTLE_ONE;
                if ((settle_q + SETTLE_ONE) == SETTLE_DONE) begin
                    ready_d = 1'b1;
                end else begin
                    ready_d = 1'b0;
                end
            end else begin
                settle_d = settle_q;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Event FSM: next state, peak tracking, dead counter and output pulses.
    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        peak_d     = peak_q;
        dead_d     = dead_q;
        trig_d     = 1'b0;
        pv_d       = 1'b0;
        amp_d      = amp_q;
        count_d    = count_q;
        base_upd_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (v2_q) begin
                    if (ready_q && above_q) begin
                        arm_d  = 4'd1;
                        peak_d = d_q;
                        if (MIN_W == 4'd1) begin
                            state_d = ST_TRIGGERED;
                            trig_d  = 1'b1;
                            count_d = count_q + 32'd1;
                        end else begin
                            state_d = ST_ARMING;
                        end
                    end else begin
                        base_upd_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMING: begin
                if (v2_q) begin
                    if (above_q) begin
                        arm_d  = arm_q + 4'd1;
                        peak_d = peak_max_s;
                        if ((arm_q + 4'd1) == MIN_W) begin
                            state_d = ST_TRIGGERED;
                            trig_d  = 1'b1;
                            count_d = count_q + 32'd1;
                        end else begin
                            state_d = ST_ARMING;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_ARMING;
                end
            end
            ST_TRIGGERED: begin
                if (v2_q) begin
                    peak_d = peak_max_s;
                    if (below_q) begin
                        pv_d    = 1'b1;
                        amp_d   = sat16(peak_max_s);
                        dead_d  = DEAD_LOAD;
                        state_d = ST_DEAD;
                    end else begin
                        state_d = ST_TRIGGERED;
                    end
                end else begin
                    state_d = ST_TRIGGERED;
                end
            end
            ST_DEAD: begin
                // Counts clocks, not samples: enable gaps do not stretch it.
                if (dead_q <= 16'd1) begin
                    dead_d  = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    dead_d  = dead_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All state flops; async reset clears everything, including an event in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xr_q     <= 16'sd0;
            v1_q     <= 1'b0;
            xs_q     <= 16'sd0;
            d_q      <= 17'sd0;
            above_q  <= 1'b0;
            below_q  <= 1'b0;
            v2_q     <= 1'b0;
            acc_q    <= '0;
            init_q   <= 1'b0;
            settle_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= ST_IDLE;
            arm_q    <= 4'd0;
            peak_q   <= 17'sd0;
            dead_q   <= 16'd0;
            trig_q   <= 1'b0;
            pv_q     <= 1'b0;
            amp_q    <= 16'sd0;
            count_q  <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            xr_q     <= xr_d;
            v1_q     <= v1_d;
            xs_q     <= xs_d;
            d_q      <= d_d;
            above_q  <= above_d;
            below_q  <= below_d;
            v2_q     <= v2_d;
            acc_q    <= acc_d;
            init_q   <= init_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            arm_q    <= arm_d;
            peak_q   <= peak_d;
            dead_q   <= dead_d;
            trig_q   <= trig_d;
            pv_q     <= pv_d;
            amp_q    <= amp_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign trigger        = trig_q;
    assign peak_valid     = pv_q;
    assign peak_amp       = amp_q;
    assign baseline_out   = baseline_s;
    assign baseline_ready = ready_q;
    assign busy           = busy_q;
    assign trig_count     = count_q;

endmodule

// File: tb/tb_selftrigger_peak_discriminator.sv
// Bench for selftrigger_peak_discriminator: directed scenarios plus random
// stimulus, each compared against a sample-level behavioural model.

module tb_selftrigger_peak_discriminator;

    localparam int BS = 6;
    localparam int MINW = 4;
    localparam int DT = 256;
    localparam int SETTLE_N = 256;
    localparam int MD_IDLE = 0, MD_ARM = 1, MD_TRIG = 2, MD_DEAD = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] x_in = 16'sd0;
    logic        [13:0] threshold = 14'd50;
    logic               trigger, peak_valid, baseline_ready, busy;
    logic signed [15:0] peak_amp, baseline_out;
    logic        [31:0] trig_count;

    selftrigger_peak_discriminator #(
        .BASELINE_SHIFT(BS), .MIN_WIDTH(MINW), .DEADTIME(DT), .SETTLE_LOG2(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .x_in(x_in),
        .threshold(threshold), .trigger(trigger), .peak_valid(peak_valid),
        .peak_amp(peak_amp), .baseline_out(baseline_out),
        .baseline_ready(baseline_ready), .busy(busy), .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int ntrig = 0, npv = 0, last_trig_cyc = -1, last_pv_cyc = -1;
    int busy_fall_cyc = -1, last_amp = 0;
    logic prev_busy = 1'b0;
    int mism = 0;
    string first_mism = "";

    // Behavioural model: samples flow through a two-slot delay line, then
    // the event rules of the discriminator are applied to each sample.
    int s1_v, s1_x, s2_v, s2_x, s2_d, s2_above, s2_below;
    longint m_acc;
    int m_init, m_settle, m_ready, m_mode, m_arm, m_peak, m_dead;
    int m_trig, m_pv, m_amp;
    int unsigned m_count;

    task automatic model_reset();
        s1_v = 0; s1_x = 0; s2_v = 0; s2_x = 0; s2_d = 0; s2_above = 0; s2_below = 0;
        m_acc = 0; m_init = 0; m_settle = 0; m_ready = 0; m_mode = MD_IDLE;
        m_arm = 0; m_peak = 0; m_dead = 0; m_trig = 0; m_pv = 0; m_amp = 0; m_count = 0;
    endtask

    function automatic int model_baseline();
        return int'(m_acc >>> BS);
    endfunction

    task automatic model_step(input logic en, input int x);
        int bl, thr;
        bl = model_baseline();
        thr = int'(threshold);
        m_trig = 0;
        m_pv = 0;
        if (m_mode == MD_DEAD) begin
            if (m_dead == 1) m_mode = MD_IDLE;
            else m_dead = m_dead - 1;
        end else if (s2_v != 0) begin
            case (m_mode)
                MD_IDLE: begin
                    if (m_ready != 0 && s2_above != 0) begin
                        m_arm = 1;
                        m_peak = s2_d;
                        if (MINW == 1) begin
                            m_mode = MD_TRIG; m_trig = 1; m_count++;
                        end else m_mode = MD_ARM;
                    end else begin
                        if (m_init == 0) begin
                            m_acc = longint'(s2_x) * (longint'(1) << BS);
                            m_init = 1;
                        end else m_acc = m_acc + s2_x - bl;
                        if (m_ready == 0) begin
                            m_settle++;
                            if (m_settle == SETTLE_N) m_ready = 1;
                        end
                    end
                end
                MD_ARM: begin
                    if (s2_above != 0) begin
                        m_arm++;
                        if (s2_d > m_peak) m_peak = s2_d;
                        if (m_arm == MINW) begin
                            m_mode = MD_TRIG; m_trig = 1; m_count++;
                        end
                    end else m_mode = MD_IDLE;
                end
                default: begin
                    if (s2_d > m_peak) m_peak = s2_d;
                    if (s2_below != 0) begin
                        m_pv = 1;
                        m_amp = (m_peak > 32767) ? 32767 : m_peak;
                        m_dead = DT;
                        m_mode = MD_DEAD;
                    end
                end
            endcase
        end
        s2_v = s1_v;
        if (s1_v != 0) begin
            s2_x = s1_x;
            s2_d = s1_x - bl;
            s2_above = (s2_d > thr) ? 1 : 0;
            s2_below = (s2_d < thr / 2) ? 1 : 0;
        end
        s1_v = en ? 1 : 0;
        if (en) s1_x = x;
    endtask

    // One clock of stimulus; the model follows and any divergence is logged.
    task automatic drive(input logic en, input int x);
        logic [67:0] exp_v, obs_v;
        enable = en;
        x_in = 16'(x);
        @(posedge clk);
        model_step(en, x);
        cyc++;
        #1;
        exp_v = {m_trig[0], m_pv[0], 16'(m_amp), 16'(model_baseline()), m_ready[0],
                 (m_mode != MD_IDLE), m_count};
        obs_v = {trigger, peak_valid, peak_amp, baseline_out, baseline_ready, busy, trig_count};
        if (obs_v !== exp_v) begin
            if (mism == 0) first_mism = $sformatf("cycle %0d dut=%h model=%h", cyc, obs_v, exp_v);
            mism++;
        end
        if (trigger) begin ntrig++; last_trig_cyc = cyc; end
        if (peak_valid) begin npv++; last_pv_cyc = cyc; last_amp = int'(peak_amp); end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        prev_busy = 1'b0;
    endtask

    // Standard event: 151,160,300,250,180,120 over a baseline of 100.
    task automatic send_event(input logic gaps, output int c4, output int c6);
        int s[6] = '{151, 160, 300, 250, 180, 120};
        c4 = -1; c6 = -1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, s[i]);
            if (i == 3) c4 = cyc;
            if (i == 5) c6 = cyc;
            if (gaps) drive(1'b0, int'($urandom_range(0, 65535)) - 32768);
        end
    endtask

    task automatic test_reset();
        mism = 0;
        do_reset();
        #1;
        checks++;
        if ({trigger, peak_valid, peak_amp, baseline_out, baseline_ready, busy, trig_count} !== 68'd0) begin
            failures++;
            $display("FAIL reset_outputs got trig=%0b pv=%0b amp=%0d base=%0d rdy=%0b busy=%0b cnt=%0d want all 0",
                     trigger, peak_valid, peak_amp, baseline_out, baseline_ready, busy, trig_count);
        end
    endtask

    task automatic test_settling();
        int t0;
        mism = 0;
        threshold = 14'd50;
        repeat (SETTLE_N) drive(1'b1, 100);
        checks++;
        if (baseline_ready !== 1'b0) begin failures++; $display("FAIL ready_early got %0b want 0", baseline_ready); end
        drive(1'b0, 0);
        checks++;
        if (baseline_ready !== 1'b0) begin failures++; $display("FAIL ready_plus1 got %0b want 0", baseline_ready); end
        drive(1'b0, 0);
        checks++;
        if (baseline_ready !== 1'b1) begin failures++; $display("FAIL ready_plus2 got %0b want 1", baseline_ready); end
        checks++;
        if (baseline_out !== 16'sd100) begin failures++; $display("FAIL settled_baseline got %0d want 100", baseline_out); end
        t0 = ntrig;
        repeat (3) drive(1'b1, 200);
        repeat (10) drive(1'b1, 100);
        checks++;
        if (ntrig !== t0) begin failures++; $display("FAIL short_200_no_trigger got %0d triggers want 0", ntrig - t0); end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL settling_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_event();
        int c4, c6;
        mism = 0;
        send_event(1'b0, c4, c6);
        repeat (4) drive(1'b1, 100);
        checks++;
        if (last_trig_cyc !== c4 + 2) begin failures++; $display("FAIL event_trigger_cycle got %0d want %0d", last_trig_cyc, c4 + 2); end
        checks++;
        if (trig_count !== 32'd1) begin failures++; $display("FAIL event_trig_count got %0d want 1", trig_count); end
        checks++;
        if (last_pv_cyc !== c6 + 2) begin failures++; $display("FAIL event_pv_cycle got %0d want %0d", last_pv_cyc, c6 + 2); end
        checks++;
        if (last_amp !== 200) begin failures++; $display("FAIL event_peak_amp got %0d want 200", last_amp); end
        repeat (270) drive(1'b1, 100);
        checks++;
        if (busy_fall_cyc !== last_pv_cyc + DT) begin failures++; $display("FAIL event_dead_len got %0d want %0d", busy_fall_cyc, last_pv_cyc + DT); end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL event_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_too_short();
        int t0;
        mism = 0;
        t0 = ntrig;
        repeat (3) drive(1'b1, 300);
        repeat (11) drive(1'b1, 100);
        checks++;
        if (ntrig !== t0 || busy !== 1'b0 || baseline_out !== 16'sd100) begin
            failures++;
            $display("FAIL too_short got trig=%0d busy=%0b base=%0d want 0 0 100", ntrig - t0, busy, baseline_out);
        end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL too_short_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_random();
        int len, amp;
        mism = 0;
        threshold = 14'd50;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                len = int'($urandom_range(1, 7));
                amp = int'($urandom_range(60, 3000));
                for (int j = 0; j < len; j++) drive(1'b1, 100 + amp + int'($urandom_range(0, 40)));
            end else begin
                drive($urandom_range(0, 3) != 0, 90 + int'($urandom_range(0, 20)));
            end
        end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL random_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_dead_time();
        int c4, c6, t0;
        mism = 0;
        threshold = 14'd50;
        do_reset();
        repeat (SETTLE_N + 2) drive(1'b1, 100);
        send_event(1'b0, c4, c6);
        for (int i = 0; i < 40; i++) if (cyc < last_pv_cyc + 10) drive(1'b1, 100);
        t0 = ntrig;
        send_event(1'b0, c4, c6);
        repeat (4) drive(1'b1, 100);
        checks++;
        if (ntrig !== t0) begin failures++; $display("FAIL dead_ignored got %0d triggers want 0", ntrig - t0); end
        for (int i = 0; i < 400; i++) if (busy) drive(1'b1, 100);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL dead_exit busy got %0b want 0", busy); end
        repeat (3) drive(1'b1, 100);
        send_event(1'b0, c4, c6);
        repeat (4) drive(1'b1, 100);
        checks++;
        if (trig_count !== 32'd2 || last_trig_cyc !== c4 + 2) begin
            failures++;
            $display("FAIL dead_retrigger got cnt=%0d at %0d want 2 at %0d", trig_count, last_trig_cyc, c4 + 2);
        end
        for (int i = 0; i < 400; i++) if (busy) drive(1'b1, 100);
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL dead_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_enable_gaps();
        int c4, c6;
        mism = 0;
        send_event(1'b1, c4, c6);
        repeat (4) drive(1'b1, 100);
        checks++;
        if (last_trig_cyc !== c4 + 2 || trig_count !== 32'd3) begin
            failures++;
            $display("FAIL gaps_trigger got cyc=%0d cnt=%0d want cyc=%0d cnt=3", last_trig_cyc, trig_count, c4 + 2);
        end
        checks++;
        if (last_pv_cyc !== c6 + 2 || last_amp !== 200) begin
            failures++;
            $display("FAIL gaps_peak got cyc=%0d amp=%0d want cyc=%0d amp=200", last_pv_cyc, last_amp, c6 + 2);
        end
        for (int i = 0; i < 400; i++) if (busy) drive(1'b1, 100);
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL gaps_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_saturation();
        int p0;
        mism = 0;
        threshold = 14'd1000;
        do_reset();
        repeat (SETTLE_N + 2) drive(1'b1, -32768);
        checks++;
        if (baseline_out !== -16'sd32768) begin failures++; $display("FAIL sat_baseline got %0d want -32768", baseline_out); end
        p0 = npv;
        repeat (4) drive(1'b1, 32767);
        repeat (5) drive(1'b1, -32768);
        checks++;
        if (npv !== p0 + 1 || last_amp !== 32767) begin
            failures++;
            $display("FAIL sat_peak got events=%0d amp=%0d want 1 32767", npv - p0, last_amp);
        end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL sat_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    task automatic test_async_reset();
        int p0;
        mism = 0;
        threshold = 14'd50;
        do_reset();
        repeat (SETTLE_N + 2) drive(1'b1, 100);
        p0 = npv;
        drive(1'b1, 151); drive(1'b1, 160); drive(1'b1, 300); drive(1'b1, 250);
        repeat (4) drive(1'b1, 180);
        checks++;
        if (busy !== 1'b1 || trig_count !== 32'd1) begin
            failures++;
            $display("FAIL async_pre busy=%0b cnt=%0d want 1 1", busy, trig_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({trigger, peak_valid, peak_amp, baseline_out, baseline_ready, busy, trig_count} !== 68'd0) begin
            failures++;
            $display("FAIL async_clear got pv=%0b amp=%0d base=%0d rdy=%0b busy=%0b cnt=%0d want all 0",
                     peak_valid, peak_amp, baseline_out, baseline_ready, busy, trig_count);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        prev_busy = 1'b0;
        repeat (SETTLE_N) drive(1'b1, 100);
        checks++;
        if (baseline_ready !== 1'b0) begin failures++; $display("FAIL async_resettle_early got %0b want 0", baseline_ready); end
        repeat (2) drive(1'b0, 0);
        checks++;
        if (baseline_ready !== 1'b1 || npv !== p0) begin
            failures++;
            $display("FAIL async_resettle got rdy=%0b extra_pv=%0d want 1 0", baseline_ready, npv - p0);
        end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL async_trace mismatches=%0d want 0 (%s)", mism, first_mism); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_settling();
        test_event();
        test_too_short();
        test_random();
        test_dead_time();
        test_enable_gaps();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
